// File: rtl/quad_encoder_scheduler.sv
// Round-robin quadrature decoder shared across NUM_CH encoder channels,
// with a host read/clear port that lands in the target channel's scan slot.
module quad_encoder_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int COUNT_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         A,
    input  logic [NUM_CH-1:0]         B,
    input  logic                      enable,
    input  logic                      rd_req,
    input  logic [$clog2(NUM_CH)-1:0] rd_ch,
    input  logic                      rd_clear,
    output logic                      rd_ack,
    output logic [COUNT_W-1:0]        rd_data,
    output logic                      rd_err,
    output logic [NUM_CH-1:0]         err_flags,
    output logic                      sweep_done
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [NUM_CH-1:0]      a_sync [SYNC_STAGES];
    logic [NUM_CH-1:0]      b_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sync_full;
    logic [1:0]             prev   [NUM_CH];
    logic [COUNT_W-1:0]     count  [NUM_CH];
    logic [NUM_CH-1:0]      err;
    logic [NUM_CH-1:0]      primed;
    logic [CH_W-1:0]        ptr;
    logic [CH_W-1:0]        ch_q;
    logic                   clr_q;
    state_t                 state, state_n;
    logic [1:0]             cur_ph, dph;
    logic [COUNT_W-1:0]     step_cnt, acc_data, cap_data;
    logic                   step_err, acc_err, cap_err;
    logic                   decode, bad_ch, access;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                a_sync[s] <= '0;
                b_sync[s] <= '0;
            end
            sync_full <= '0;
        end else begin
            a_sync[0] <= A;
            b_sync[0] <= B;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                a_sync[s] <= a_sync[s-1];
                b_sync[s] <= b_sync[s-1];
            end
            sync_full <= {sync_full[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Slots are skipped until the synchronizer holds real pin values, so the
    // reset zeros are never primed as a phase and mistaken for a step later.
    always_comb begin
        cur_ph = {b_sync[SYNC_STAGES-1][ptr],
                  a_sync[SYNC_STAGES-1][ptr] ^ b_sync[SYNC_STAGES-1][ptr]};
        dph      = cur_ph - prev[ptr];
        decode   = enable && sync_full[SYNC_STAGES-1];
        step_cnt = count[ptr];
        step_err = err[ptr];
        if (decode && primed[ptr]) begin
            case (dph)
                2'd1:    step_cnt = count[ptr] + 1'b1;
                2'd3:    step_cnt = count[ptr] - 1'b1;
                2'd2:    step_err = 1'b1;
                default: ;
            endcase
        end

        bad_ch   = (int'(ch_q) >= NUM_CH);
        access   = (state == WAIT) && (bad_ch || !enable || (ptr == ch_q));
        acc_data = count[ch_q];
        acc_err  = err[ch_q];
        if (bad_ch) begin
            acc_data = '0;
            acc_err  = 1'b1;
        end else if (enable) begin
            acc_data = step_cnt;
            acc_err  = step_err;
        end

        state_n = state;
        case (state)
            IDLE:    if (rd_req) state_n = WAIT;
            WAIT:    if (access) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                count[c] <= '0;
                prev[c]  <= '0;
            end
            err        <= '0;
            primed     <= '0;
            ptr        <= '0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (enable) begin
                ptr        <= (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + 1'b1;
                sweep_done <= (ptr == CH_W'(NUM_CH - 1));
                if (decode) begin
                    prev[ptr]   <= cur_ph;
                    primed[ptr] <= 1'b1;
                    count[ptr]  <= step_cnt;
                    err[ptr]    <= step_err;
                end
            end
            // Clear after capture: a step in the access slot is reported, then dropped.
            if (access && clr_q && !bad_ch) begin
                count[ch_q] <= '0;
                err[ch_q]   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ch_q     <= '0;
            clr_q    <= 1'b0;
            cap_data <= '0;
            cap_err  <= 1'b0;
            rd_ack   <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            state  <= state_n;
            rd_ack <= 1'b0;
            if (state == IDLE && rd_req) begin
                ch_q  <= rd_ch;
                clr_q <= rd_clear;
            end
            if (access) begin
                cap_data <= acc_data;
                cap_err  <= acc_err;
            end
            if (state == RESP) begin
                rd_ack  <= 1'b1;
                rd_data <= cap_data;
                rd_err  <= cap_err;
            end
        end
    end

    assign err_flags = err;

endmodule

// File: tb/tb_quad_encoder_scheduler.sv
// Directed bench for quad_encoder_scheduler; COUNT_W is narrowed so the
// positive-wrap case can be reached by stepping in a short run.
module tb_quad_encoder_scheduler;
    localparam int N  = 4;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  A, B;
    logic          enable, rd_req, rd_clear;
    logic [1:0]    rd_ch;
    logic          rd_ack, rd_err, sweep_done;
    logic [CW-1:0] rd_data;
    logic [N-1:0]  err_flags;

    int errors = 0;
    int checks = 0;

    quad_encoder_scheduler #(.NUM_CH(N), .COUNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .enable(enable),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_clear(rd_clear),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err),
        .err_flags(err_flags), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [1:0] ph_ab(input int idx);
        case (idx % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic set_ph(input int c, input logic [1:0] ab);
        A[c] = ab[1];
        B[c] = ab[0];
    endtask

    // Called on a negedge; raises the request at once. Timeout leaves lat=0, data=x.
    task automatic do_read(input logic [1:0] ch, input logic clr,
                           output logic [CW-1:0] d, output logic e, output int lat);
        rd_ch = ch; rd_clear = clr; rd_req = 1'b1;
        lat = 0; d = 'x; e = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_ack) begin
                lat = i; d = rd_data; e = rd_err;
                break;
            end
        end
        rd_req = 1'b0; rd_clear = 1'b0;
    endtask

    task automatic test_reset;
        int sw;
        reset = 1'b1; tick(3);
        reset = 1'b0;
        checks += 5;
        if (rd_ack !== 1'b0)   begin errors++; $display("FAIL reset_ack got %b exp 0", rd_ack); end
        if (rd_data !== '0)    begin errors++; $display("FAIL reset_data got %h exp 0", rd_data); end
        if (rd_err !== 1'b0)   begin errors++; $display("FAIL reset_err got %b exp 0", rd_err); end
        if (err_flags !== '0)  begin errors++; $display("FAIL reset_flags got %b exp 0", err_flags); end
        if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_sweep got %b exp 0", sweep_done); end
        sw = 0;
        for (int i = 0; i < 8; i++) begin tick(1); if (sweep_done) sw++; end
        checks++;
        if (sw !== 2) begin errors++; $display("FAIL sweep_rate got %0d exp 2", sw); end
    endtask

    task automatic test_forward;
        logic [CW-1:0] d; logic e; int lat;
        for (int i = 1; i <= 4; i++) begin set_ph(1, ph_ab(i)); tick(8); end
        do_read(2'd1, 1'b0, d, e, lat);
        checks += 2;
        if (d !== CW'(4)) begin errors++; $display("FAIL fwd_count got %h exp %h", d, CW'(4)); end
        if (e !== 1'b0)   begin errors++; $display("FAIL fwd_err got %b exp 0", e); end
        for (int c = 0; c < N; c += 2) begin
            do_read(2'(c), 1'b0, d, e, lat);
            checks++;
            if (d !== '0) begin errors++; $display("FAIL other_ch%0d got %h exp 0", c, d); end
        end
        do_read(2'd3, 1'b0, d, e, lat);
        checks++;
        if (d !== '0) begin errors++; $display("FAIL other_ch3 got %h exp 0", d); end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [CW-1:0] d1;
        enable = 1'b0; tick(1);
        rd_ch = 2'd1; rd_clear = 1'b1; rd_req = 1'b1;
        for (int t = 0; t < 2; t++) begin
            lat = 0; d1 = 'x;
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk); @(negedge clk);
                if (rd_ack) begin lat = i; d1 = rd_data; break; end
            end
            checks += 2;
            if (lat !== 3) begin errors++; $display("FAIL b2b_lat%0d got %0d exp 3", t, lat); end
            if (d1 !== ((t == 0) ? CW'(4) : CW'(0)))
                begin errors++; $display("FAIL b2b_data%0d got %h exp %h", t, d1, (t == 0) ? CW'(4) : CW'(0)); end
        end
        rd_req = 1'b0; rd_clear = 1'b0;
        enable = 1'b1; tick(2);
    endtask

    task automatic test_reverse;
        logic [CW-1:0] d; logic e; int lat;
        set_ph(2, 2'b01); tick(8);
        set_ph(2, 2'b11); tick(8);
        do_read(2'd2, 1'b1, d, e, lat);
        checks += 2;
        if (d !== {{(CW-1){1'b1}}, 1'b0}) begin errors++; $display("FAIL rev_count got %h exp %h", d, {{(CW-1){1'b1}}, 1'b0}); end
        if (e !== 1'b0) begin errors++; $display("FAIL rev_err got %b exp 0", e); end
        do_read(2'd2, 1'b0, d, e, lat);
        checks++;
        if (d !== '0) begin errors++; $display("FAIL rev_cleared got %h exp 0", d); end
    endtask

    task automatic test_error;
        logic [CW-1:0] d; logic e; int lat;
        set_ph(0, 2'b11);
        for (int i = 0; i < N + 3; i++) begin tick(1); if (err_flags[0]) break; end
        checks++;
        if (err_flags[0] !== 1'b1) begin errors++; $display("FAIL err_detect got %b exp 1", err_flags[0]); end
        do_read(2'd0, 1'b1, d, e, lat);
        checks += 3;
        if (d !== '0)   begin errors++; $display("FAIL err_count got %h exp 0", d); end
        if (e !== 1'b1) begin errors++; $display("FAIL err_rd got %b exp 1", e); end
        if (err_flags[0] !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err_flags[0]); end
    endtask

    task automatic wait_sweep(input string tag);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin tick(1); if (sweep_done) begin seen = 1; break; end end
        checks++;
        if (!seen) begin errors++; $display("FAIL %s_sweep got 0 exp 1", tag); end
    endtask

    task automatic test_latency;
        logic [CW-1:0] d; logic e; int lat; int sw;
        // Request during ch3's own slot: it just misses it, WAIT starts at ptr=0.
        wait_sweep("lat_max"); tick(3);
        do_read(2'd3, 1'b0, d, e, lat);
        checks += 2;
        if (lat !== 6) begin errors++; $display("FAIL lat_max got %0d exp 6", lat); end
        if (d !== '0)  begin errors++; $display("FAIL lat_max_data got %h exp 0", d); end
        wait_sweep("lat_min"); tick(2);
        do_read(2'd3, 1'b0, d, e, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL lat_min got %0d exp 3", lat); end
        enable = 1'b0; tick(1);
        sw = 0;
        for (int i = 0; i < 8; i++) begin tick(1); if (sweep_done) sw++; end
        checks++;
        if (sw !== 0) begin errors++; $display("FAIL halt_sweep got %0d exp 0", sw); end
        do_read(2'd3, 1'b0, d, e, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL lat_halted got %0d exp 3", lat); end
        enable = 1'b1; tick(1);
    endtask

    task automatic test_wrap;
        logic [CW-1:0] d; logic e; int lat;
        for (int i = 1; i < (1 << (CW - 1)); i++) begin set_ph(1, ph_ab(i)); tick(6); end
        do_read(2'd1, 1'b0, d, e, lat);
        checks++;
        if (d !== {1'b0, {(CW-1){1'b1}}}) begin errors++; $display("FAIL wrap_max got %h exp %h", d, {1'b0, {(CW-1){1'b1}}}); end
        set_ph(1, ph_ab(1 << (CW - 1))); tick(6);
        do_read(2'd1, 1'b0, d, e, lat);
        checks += 2;
        if (d !== {1'b1, {(CW-1){1'b0}}}) begin errors++; $display("FAIL wrap_min got %h exp %h", d, {1'b1, {(CW-1){1'b0}}}); end
        if (e !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", e); end
    endtask

    task automatic test_reset_mid;
        logic [CW-1:0] d; logic e; int lat; int acks;
        wait_sweep("mid"); tick(3);
        rd_ch = 2'd3; rd_clear = 1'b0; rd_req = 1'b1;
        tick(2);
        reset = 1'b1; rd_req = 1'b0;
        for (int c = 0; c < N; c++) set_ph(c, 2'b11);
        acks = 0;
        for (int i = 0; i < 3; i++) begin tick(1); if (rd_ack) acks++; end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(1); if (rd_ack) acks++; end
        checks += 2;
        if (acks !== 0) begin errors++; $display("FAIL mid_ack got %0d exp 0", acks); end
        if (err_flags !== '0) begin errors++; $display("FAIL mid_flags got %b exp 0", err_flags); end
        for (int c = 0; c < N; c++) begin
            do_read(2'(c), 1'b0, d, e, lat);
            checks += 2;
            if (d !== '0)   begin errors++; $display("FAIL mid_count%0d got %h exp 0", c, d); end
            if (e !== 1'b0) begin errors++; $display("FAIL mid_err%0d got %b exp 0", c, e); end
        end
    endtask

    initial begin
        A = '0; B = '0; enable = 1'b1;
        rd_req = 1'b0; rd_ch = '0; rd_clear = 1'b0; reset = 1'b1;
        test_reset();
        test_forward();
        test_back_to_back();
        test_reverse();
        test_error();
        test_latency();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quad_encoder_scheduler.md
Name: quad_encoder_scheduler

Overview:
Time-multiplexes one quadrature step decoder across NUM_CH encoder channels. Per-channel phase, position and error state are held in internal registers. A round-robin scanner visits one channel per clock. A host read/clear port is arbitrated against the scanner, so each read-modify-write lands in that channel's scan slot. The block sits between the raw encoder pins and the position-readout logic, and replaces per-channel decoders.

Parameters:
NUM_CH, 4, number of encoder channels (>=2)
COUNT_W, 16, position counter width; two's-complement, wraps
SYNC_STAGES, 2, synchronizer flops on each A/B input (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
A  in  NUM_CH  encoder channel A inputs, asynchronous
B  in  NUM_CH  encoder channel B inputs, asynchronous
enable  in  1  scanner runs when 1; halts pointer when 0
rd_req  in  1  host request, level; held until rd_ack
rd_ch  in  clog2(NUM_CH)  channel to access; stable while rd_req=1
rd_clear  in  1  with request: zero count and error after read; stable with rd_req
rd_ack  out  1  one-cycle pulse, response valid
rd_data  out  COUNT_W  count value; held until next rd_ack
rd_err  out  1  error flag of accessed channel, or bad channel index; held with rd_data
err_flags  out  NUM_CH  live sticky per-channel error flags
sweep_done  out  1  one-cycle pulse when pointer wraps NUM_CH-1 -> 0

Behaviour:
- Reset values: all count=0, err=0, primed=0, ptr=0, FSM=IDLE, rd_ack=0, rd_data=0, rd_err=0, sweep_done=0, sync flops=0.
- Phase encoding of synchronized {A,B}:
  - 00=S0, 10=S1, 11=S2, 01=S3.
  - Forward steps: S0->S1->S2->S3->S0, each +1.
  - Reverse steps: each -1.
  - Same phase: 0.
  - Diagonal (S0<->S2, S1<->S3): illegal; err[c]<=1 (sticky), count unchanged.
- Scan cycle (enable=1), for c=ptr:
  - Compare sync phase[c] with prev[c], update count[c] mod 2^COUNT_W, prev[c]<=phase.
  - ptr<=ptr+1, wrapping at NUM_CH-1 -> 0 and pulsing sweep_done in that cycle.
- First scan after reset (primed[c]=0): load prev[c] only, no count or err change; set primed[c].
- enable=0: ptr frozen, no decoding, sweep_done=0; prev/count retained.
- Host FSM:
  - IDLE: rd_req=1 -> latch rd_ch/rd_clear, go WAIT.
  - WAIT: access when (enable=1 and ptr==ch) or enable=0; go RESP.
  - RESP: rd_ack=1 for one cycle, go IDLE.
- Access semantics:
  - rd_data = count[ch] including this cycle's step (post-update value).
  - rd_err = err[ch] post-update.
  - If rd_clear: count[ch]<=0, err[ch]<=0 after capture. A step in the access cycle is reported, not lost twice.
- Latency rd_req rise -> rd_ack: min 3 cycles, max NUM_CH+2 cycles with enable=1; exactly 3 with enable=0.
- Back-to-back: rd_req still 1 in IDLE after ack starts a new transaction.
- rd_ch >= NUM_CH (non-power-of-2 NUM_CH): WAIT completes immediately; ack with rd_data=0, rd_err=1, no state change.
- Wrap-around: count 2^(COUNT_W-1)-1 +1 -> -2^(COUNT_W-1); 0 -1 -> all ones. No saturation.
- Reset asserted mid-transaction: transaction aborted, no rd_ack; all state as reset.
- Encoder input change faster than one step per NUM_CH+SYNC_STAGES cycles per channel is out of spec; detection surfaces as err.

Test Plan:
1. Reset, enable=1, ch1 phases 00->10->11->01->00 (each held 8 cycles), read ch1 -> rd_data=4, rd_err=0, others 0.
2. ch2 reverse sequence S0->S3->S2 held 8 cycles each, read with rd_clear=1 -> rd_data=0xFFFE; next read ch2 -> 0.
3. ch0 jumps 00->11 -> err_flags[0]=1 within NUM_CH+SYNC_STAGES+1 cycles, count unchanged; read rd_clear -> rd_err=1, then err_flags[0]=0.
4. Read ch3 when ptr=0 with enable=1, NUM_CH=4 -> rd_ack exactly 6 cycles after rd_req; with enable=0 -> 3 cycles.
5. Preload ch1 count to 0x7FFF via 32767 forward steps, one more step -> read 0x8000.
6. Assert reset during WAIT -> no rd_ack; all counts 0; first post-reset scan with inputs 11 produces no step or error.
